// File: rtl/nx_fifo_pkg.sv
// Shared helpers for the nx FIFO family: derived widths, wrapping pointer
// increment and the decoded per-cycle operation type.
package nx_fifo_pkg;

  // Accepted operations in one cycle, encoded as {write_ok, read_ok}
  typedef enum logic [1:0] {
    OpNone  = 2'b00,
    OpRead  = 2'b01,
    OpWrite = 2'b10,
    OpBoth  = 2'b11
  } fifo_op_e;

  // Pointer width: enough to index DEPTH entries, never less than one bit
  function automatic int unsigned calc_ptr_w(int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Count width: must represent 0..DEPTH inclusive
  function automatic int unsigned calc_cnt_w(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap at depth-1 so non-power-of-two depths work
  function automatic int unsigned ptr_inc(int unsigned ptr, int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/nx_fifo_flex_ctrl.sv
// Control path for nx_fifo_flex: read/write pointers, occupancy count,
// status flags, high-water mark and registered error pulses.
module nx_fifo_flex_ctrl
  import nx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned AFULL_THRESH  = DEPTH - 1,
  parameter int unsigned AEMPTY_THRESH = 1,
  localparam int unsigned PtrW         = calc_ptr_w(DEPTH),
  localparam int unsigned CntW         = calc_cnt_w(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wen_i,
  input  logic            ren_i,
  input  logic            clear_i,
  input  logic            hwm_clr_i,
  output logic            wr_en_o,
  output logic [PtrW-1:0] wptr_o,
  output logic [PtrW-1:0] rptr_o,
  output logic            empty_o,
  output logic            full_o,
  output logic            almost_full_o,
  output logic            almost_empty_o,
  output logic [CntW-1:0] used_slots_o,
  output logic [CntW-1:0] free_slots_o,
  output logic [CntW-1:0] hwm_o,
  output logic            underflow_o,
  output logic            overflow_o
);

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] hwm_q, hwm_d;
  logic            uflow_q, uflow_d;
  logic            oflow_q, oflow_d;
  logic            wr_ok, rd_ok;
  fifo_op_e        op;

  // Status flags decode purely from the count register
  always_comb begin
    empty_o        = (count_q == '0);
    full_o         = (count_q == CntW'(DEPTH));
    almost_full_o  = (count_q >= CntW'(AFULL_THRESH));
    almost_empty_o = (count_q <= CntW'(AEMPTY_THRESH));
    used_slots_o   = count_q;
    free_slots_o   = CntW'(DEPTH) - count_q;
    hwm_o          = hwm_q;
    underflow_o    = uflow_q;
    overflow_o     = oflow_q;
    wptr_o         = wptr_q;
    rptr_o         = rptr_q;
  end

  // Acceptance: on full the read wins, on empty the write wins
  always_comb begin
    wr_ok   = wen_i && !full_o;
    rd_ok   = ren_i && !empty_o;
    op      = fifo_op_e'({wr_ok, rd_ok});
    wr_en_o = wr_ok && !clear_i && rst_ni;
  end

  // Next-state for pointers, count, hwm and error pulses
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    oflow_d = wen_i && full_o;
    uflow_d = ren_i && empty_o;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      oflow_d = 1'b0;
      uflow_d = 1'b0;
    end else begin
      unique case (op)
        OpWrite: begin
          wptr_d  = PtrW'(ptr_inc(32'(wptr_q), DEPTH));
          count_d = count_q + CntW'(1);
        end
        OpRead: begin
          rptr_d  = PtrW'(ptr_inc(32'(rptr_q), DEPTH));
          count_d = count_q - CntW'(1);
        end
        OpBoth: begin
          wptr_d = PtrW'(ptr_inc(32'(wptr_q), DEPTH));
          rptr_d = PtrW'(ptr_inc(32'(rptr_q), DEPTH));
        end
        OpNone: ;
        default: ;
      endcase
    end
    // hwm_clr restarts tracking from the upcoming occupancy, not from zero
    if (hwm_clr_i) begin
      hwm_d = count_d;
    end else begin
      hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      hwm_q   <= '0;
      uflow_q <= 1'b0;
      oflow_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      hwm_q   <= hwm_d;
      uflow_q <= uflow_d;
      oflow_q <= oflow_d;
    end
  end

endmodule

// File: rtl/nx_fifo_flex.sv
// Flexible-depth synchronous FIFO: storage array and read mux around
// nx_fifo_flex_ctrl. Depth need not be a power of two.
module nx_fifo_flex
  import nx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned WIDTH         = 1,
  parameter int unsigned AFULL_THRESH  = DEPTH - 1,
  parameter int unsigned AEMPTY_THRESH = 1,
  parameter bit          DATA_RESET    = 1'b0,
  localparam int unsigned CNT_W        = calc_cnt_w(DEPTH),
  localparam int unsigned PTR_W        = calc_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ren,
  input  logic             clear,
  input  logic             hwm_clr,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] used_slots,
  output logic [CNT_W-1:0] free_slots,
  output logic [CNT_W-1:0] hwm,
  output logic             underflow,
  output logic             overflow
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  nx_fifo_flex_ctrl #(
    .DEPTH         (DEPTH),
    .AFULL_THRESH  (AFULL_THRESH),
    .AEMPTY_THRESH (AEMPTY_THRESH)
  ) u_ctrl (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .wen_i          (wen),
    .ren_i          (ren),
    .clear_i        (clear),
    .hwm_clr_i      (hwm_clr),
    .wr_en_o        (wr_en),
    .wptr_o         (wptr),
    .rptr_o         (rptr),
    .empty_o        (empty),
    .full_o         (full),
    .almost_full_o  (almost_full),
    .almost_empty_o (almost_empty),
    .used_slots_o   (used_slots),
    .free_slots_o   (free_slots),
    .hwm_o          (hwm),
    .underflow_o    (underflow),
    .overflow_o     (overflow)
  );

  if (DATA_RESET) begin : g_mem_rst
    // Storage write; array cleared on reset
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          mem_q[i] <= '0;
        end
      end else if (wr_en) begin
        mem_q[wptr] <= wdata;
      end
    end
  end else begin : g_mem
    // Storage write; contents survive reset
    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem_q[wptr] <= wdata;
      end
    end
  end

  // Head entry, forced to zero when nothing is stored
  always_comb begin
    rdata = empty ? '0 : mem_q[rptr];
  end

endmodule

// File: tb/tb_nx_fifo_flex.sv
// Scoreboard bench for nx_fifo_flex (DEPTH=5, WIDTH=8, AF=4, AE=1, DATA_RESET=1).
module tb_nx_fifo_flex;

  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wen = 1'b0;
  logic       ren = 1'b0;
  logic       clear = 1'b0;
  logic       hwm_clr = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       empty, full, almost_full, almost_empty, underflow, overflow;
  logic [2:0] used_slots, free_slots, hwm;

  nx_fifo_flex #(
    .DEPTH         (DEPTH),
    .WIDTH         (8),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE),
    .DATA_RESET    (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wen          (wen),
    .wdata        (wdata),
    .ren          (ren),
    .clear        (clear),
    .hwm_clr      (hwm_clr),
    .rdata        (rdata),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .used_slots   (used_slots),
    .free_slots   (free_slots),
    .hwm          (hwm),
    .underflow    (underflow),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rdata;
    int empty, full, afull, aempty, uflow, oflow;
    int used, free, hwm;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mq[$];
  int         m_hwm = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue the expected post-edge state
  task automatic step(input bit r, input bit w, input logic [7:0] d, input bit rd,
                      input bit c, input bit hc);
    exp_t e;
    int   sz;
    bit   was_full, was_empty;
    int   uf, of;
    @(negedge clk);
    rst_n = r; wen = w; wdata = d; ren = rd; clear = c; hwm_clr = hc;
    uf = 0;
    of = 0;
    if (!r) begin
      mq.delete();
      m_hwm = 0;
    end else if (c) begin
      mq.delete();
      if (hc) m_hwm = 0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      of = (w && was_full) ? 1 : 0;
      uf = (rd && was_empty) ? 1 : 0;
      if (rd && !was_empty) void'(mq.pop_front());
      if (w && !was_full) mq.push_back(d);
      if (hc || mq.size() > m_hwm) m_hwm = mq.size();
    end
    sz       = mq.size();
    e.rdata  = (sz != 0) ? int'(mq[0]) : 0;
    e.empty  = (sz == 0) ? 1 : 0;
    e.full   = (sz == DEPTH) ? 1 : 0;
    e.afull  = (sz >= AF) ? 1 : 0;
    e.aempty = (sz <= AE) ? 1 : 0;
    e.uflow  = uf;
    e.oflow  = of;
    e.used   = sz;
    e.free   = DEPTH - sz;
    e.hwm    = m_hwm;
    exp_q.push_back(e);
  endtask

  // Monitor: compares DUT outputs just after each edge against the queued entry
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rdata", int'(rdata), e.rdata);
        chk("empty", int'(empty), e.empty);
        chk("full", int'(full), e.full);
        chk("almost_full", int'(almost_full), e.afull);
        chk("almost_empty", int'(almost_empty), e.aempty);
        chk("used_slots", int'(used_slots), e.used);
        chk("free_slots", int'(free_slots), e.free);
        chk("hwm", int'(hwm), e.hwm);
        chk("underflow", int'(underflow), e.uflow);
        chk("overflow", int'(overflow), e.oflow);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned wp;
    bit r, c, hc, w, rd;

    step(0, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'hFF, 1, 0, 0);

    // Fill to full, then drain in order
    for (int i = 0; i < 5; i++) step(1, 1, 8'(8'h10 + i), 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 8'h00, 1, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);

    // Pointer wrap at occupancy 2
    step(1, 1, 8'h20, 0, 0, 0);
    step(1, 1, 8'h21, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 1, 8'(8'h30 + i), 1, 0, 0);
    step(1, 0, 8'h00, 1, 0, 0);
    step(1, 0, 8'h00, 1, 0, 0);

    // Overflow on full with simultaneous read, underflow on empty
    for (int i = 0; i < 5; i++) step(1, 1, 8'(8'h40 + i), 0, 0, 0);
    step(1, 1, 8'hAA, 1, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 8'h00, 1, 0, 0);
    step(1, 1, 8'h5A, 1, 0, 0);
    step(1, 0, 8'h00, 1, 0, 0);
    step(1, 0, 8'h00, 1, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);

    // hwm_clr at zero, fill 3, clear with a write, hwm kept then cleared
    step(1, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 8'(8'h50 + i), 0, 0, 0);
    step(1, 1, 8'h55, 0, 1, 0);
    step(1, 0, 8'h00, 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 1);

    // Reset mid-operation, then a fresh write/read
    for (int i = 0; i < 3; i++) step(1, 1, 8'(8'h60 + i), 0, 0, 0);
    step(0, 1, 8'h66, 0, 0, 0);
    step(1, 1, 8'h77, 0, 0, 0);
    step(1, 0, 8'h00, 1, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0);

    // Randomised traffic with alternating write/read bias
    for (int i = 0; i < 600; i++) begin
      wp = (((i / 50) % 2) == 0) ? 75 : 25;
      r  = ($urandom_range(0, 149) != 0);
      c  = ($urandom_range(0, 59) == 0);
      hc = ($urandom_range(0, 39) == 0);
      w  = ($urandom_range(0, 99) < wp);
      rd = ($urandom_range(0, 99) < (100 - wp));
      step(r, w, 8'($urandom), rd, c, hc);
    end
    step(1, 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nx_fifo_flex.md
# nx_fifo_flex

Parametrised synchronous single-clock FIFO, successor to the fixed power-of-two library FIFO. Supports any depth ≥ 2 (non-power-of-two pointer wrap), arbitrary width, programmable almost-full/almost-empty flags, a resettable high-water mark and optional storage reset. It is a drop-in buffer for datapath stages in the common nx_library.

## Interface
Parameters:
- DEPTH, 4: number of entries, ≥ 2, any integer.
- WIDTH, 1: data width in bits, ≥ 1.
- AFULL_THRESH, DEPTH-1: almost_full asserts when used_slots ≥ this value; range 1..DEPTH.
- AEMPTY_THRESH, 1: almost_empty asserts when used_slots ≤ this value; range 0..DEPTH-1.
- DATA_RESET, 0: 1 = storage array cleared to 0 on reset.

Derived: CNT_W = $clog2(DEPTH+1); PTR_W = max(1, $clog2(DEPTH)).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- wen  in  1  write request.
- wdata  in  WIDTH  write data.
- ren  in  1  read request (pops the head).
- clear  in  1  synchronous flush.
- hwm_clr  in  1  resets high-water mark.
- rdata  out  WIDTH  head entry; 0 when empty.
- empty  out  1  used_slots == 0.
- full  out  1  used_slots == DEPTH.
- almost_full  out  1  see AFULL_THRESH.
- almost_empty  out  1  see AEMPTY_THRESH.
- used_slots  out  CNT_W  current occupancy.
- free_slots  out  CNT_W  DEPTH − used_slots.
- hwm  out  CNT_W  maximum used_slots since reset/hwm_clr.
- underflow  out  1  registered error pulse.
- overflow  out  1  registered error pulse.

## Operation
- Write accepted iff wen && !full: entry stored at wptr, wptr advances.
- Read accepted iff ren && !empty: rptr advances.
- Pointers wrap DEPTH−1 → 0 explicitly; no reliance on power-of-two rollover.
- Occupancy is held in a count register: +1 for write only, −1 for read only, unchanged for both or neither.
- When full, a simultaneous wen and ren: the read is accepted and the write is rejected. This raises overflow. Same-cycle pass-through on full is not supported.
- When empty, a simultaneous wen and ren: the write is accepted and the read is rejected. This raises underflow.
- clear: rptr, wptr and count go to 0 and underflow/overflow go to 0. clear overrides wen/ren in that cycle, and no error is flagged. Storage contents and hwm are untouched.
- hwm: the next-cycle value is max(hwm, next count). hwm_clr loads the next count, not 0. On reset hwm = 0.
- Flags (empty, full, almost_*, used/free_slots) decode combinationally from the count register, so there are no combinational paths from inputs.
- rdata = empty ? 0 : mem[rptr]. It is combinational from registered state.

## Timing
- Reset values: count 0, empty 1, full 0, almost_empty 1 (AEMPTY_THRESH ≥ 0), almost_full 0, used_slots 0, free_slots DEPTH, hwm 0, underflow 0, overflow 0, rdata 0. Storage is 0 only when DATA_RESET = 1.
- Reset mid-operation: all state returns to the reset values at the next edge, regardless of wen/ren/clear.
- Write-to-read latency: a write at edge N makes empty 0 and rdata valid after edge N.
- Read: rdata updates to the next entry after the popping edge.
- underflow/overflow: single-cycle pulse in the cycle after the offending request. One pulse per offending cycle; back-to-back violations give a continuous high.
- Flags and hwm change on the same edge as count.

## Structure
- Package nx_fifo_pkg: a function computing PTR_W/CNT_W and a pointer-increment-with-wrap function, shared with other nx FIFOs.
- Sub-module nx_fifo_flex_ctrl: pointers, count, flags, hwm and error pulses (parameters DEPTH, AFULL_THRESH, AEMPTY_THRESH).
- The top level holds the storage array and the rdata mux.
- Storage is a reg array, with no clock gating.

## Test plan
- DEPTH=5, WIDTH=8: write 0x10..0x14 → full=1, used=5, free=0, hwm=5. Read 5 times → rdata 0x10..0x14 in order, then empty=1, rdata=0.
- DEPTH=5: 12 write/read pairs at occupancy 2 → pointers wrap past index 4, data order preserved, no error pulses.
- Full + wen + ren → one entry read, write dropped, overflow=1 next cycle only, used=4. Empty + ren → underflow pulse, count stays 0.
- AFULL_THRESH=4, AEMPTY_THRESH=1: fill 0→5 → almost_empty high at counts 0–1, almost_full high at counts 4–5.
- Fill 3, clear + wen same cycle → count 0, empty=1, no overflow, hwm stays 3. hwm_clr with count 0 → hwm=0.
- rst_n=0 asserted while count=3 with wen=1 → next edge: all outputs at reset values. With DATA_RESET=1, a later single write/read returns the written value, not stale data.
